// File: rtl/scd_frame_serializer.sv
// Serial column driver frame serializer: captures an L-bit frame, shifts it out
// over scd_sdclk/scd_data to NUM_CH cascaded driver chips, then strobes scd_load_n.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_RST   | scd_rst_n held low for RST_W cycles, pending blank cleared
// ST_IDLE  | frame_ready high, waiting for a frame or a blank request
// ST_SHIFT | shifting L bits, CLK_DIV cycles per scd_sdclk half-period
// ST_LOAD  | scd_load_n held low for LOAD_W cycles, then frame_done
module scd_frame_serializer #(
    parameter int FRAME_W   = 25,
    parameter int NUM_CH    = 2,
    parameter int CLK_DIV   = 2,
    parameter int LOAD_W    = 2,
    parameter int RST_W     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                        cph1,
    input  logic                        pon,
    input  logic                        frame_valid,
    output logic                        frame_ready,
    input  logic [FRAME_W*NUM_CH-1:0]   frame_data,
    input  logic                        blank_req,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        scd_sdclk,
    output logic                        scd_data,
    output logic                        scd_load_n,
    output logic                        scd_rst_n
);

    localparam int L    = FRAME_W * NUM_CH;
    localparam int BW   = $clog2(L + 1);
    localparam int TM0  = (CLK_DIV > LOAD_W) ? CLK_DIV : LOAD_W;
    localparam int TMAX = (TM0 > RST_W) ? TM0 : RST_W;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] DIV_RELOAD  = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] LOAD_RELOAD = TW'(LOAD_W - 1);
    localparam logic [TW-1:0] RST_RELOAD  = TW'(RST_W - 1);
    localparam logic [BW-1:0] BIT_LOAD    = BW'(L);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LOAD  = 2'd3
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic [BW-1:0]   bit_cnt;
    logic [L-1:0]    shreg;
    logic            sclk_hi;
    logic            blank_pend;

    always_ff @(posedge cph1) begin
        if (pon) begin
            state       <= ST_RST;
            timer       <= RST_RELOAD;
            bit_cnt     <= '0;
            shreg       <= '0;
            sclk_hi     <= 1'b0;
            blank_pend  <= 1'b0;
            frame_ready <= 1'b0;
            busy        <= 1'b1;
            frame_done  <= 1'b0;
            scd_sdclk   <= 1'b0;
            scd_data    <= 1'b0;
            scd_load_n  <= 1'b1;
            scd_rst_n   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_RST: begin
                    blank_pend <= 1'b0;
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else begin
                        scd_rst_n <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (blank_req || blank_pend) begin
                        // Blank wins over a simultaneous frame offer.
                        state       <= ST_RST;
                        timer       <= RST_RELOAD;
                        scd_rst_n   <= 1'b0;
                        frame_ready <= 1'b0;
                        busy        <= 1'b1;
                        blank_pend  <= 1'b0;
                    end else if (frame_valid && frame_ready) begin
                        // Start as if a high phase just ended so the first
                        // bit is presented with a full low phase of setup.
                        shreg       <= frame_data;
                        bit_cnt     <= BIT_LOAD;
                        sclk_hi     <= 1'b1;
                        timer       <= '0;
                        frame_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ST_SHIFT;
                    end else begin
                        frame_ready <= 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (blank_req) begin
                        blank_pend <= 1'b1;
                    end
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else if (sclk_hi) begin
                        scd_sdclk <= 1'b0;
                        sclk_hi   <= 1'b0;
                        if (bit_cnt == '0) begin
                            scd_data   <= 1'b0;
                            scd_load_n <= 1'b0;
                            timer      <= LOAD_RELOAD;
                            state      <= ST_LOAD;
                        end else begin
                            if (MSB_FIRST != 0) begin
                                scd_data <= shreg[L-1];
                                shreg    <= shreg << 1;
                            end else begin
                                scd_data <= shreg[0];
                                shreg    <= shreg >> 1;
                            end
                            bit_cnt <= bit_cnt - BW'(1);
                            timer   <= DIV_RELOAD;
                        end
                    end else begin
                        scd_sdclk <= 1'b1;
                        sclk_hi   <= 1'b1;
                        timer     <= DIV_RELOAD;
                    end
                end

                ST_LOAD: begin
                    if (blank_req) begin
                        blank_pend <= 1'b1;
                    end
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else begin
                        scd_load_n  <= 1'b1;
                        frame_done  <= 1'b1;
                        busy        <= 1'b0;
                        frame_ready <= !(blank_req || blank_pend);
                        state       <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_RST;
                    timer <= RST_RELOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scd_frame_serializer.sv
// Scoreboard bench for scd_frame_serializer: a default 2-chip instance and a
// single-chip LSB-first instance with CLK_DIV=1.
module tb_scd_frame_serializer;

    logic clk;
    logic pon;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    logic        fv_a, fr_a, blank_a, busy_a, done_a, sdclk_a, data_a, load_n_a, rst_n_a;
    logic [49:0] fd_a;
    logic        fv_b, fr_b, blank_b, busy_b, done_b, sdclk_b, data_b, load_n_b, rst_n_b;
    logic [24:0] fd_b;

    scd_frame_serializer u_dut_a (
        .cph1(clk), .pon(pon), .frame_valid(fv_a), .frame_ready(fr_a), .frame_data(fd_a),
        .blank_req(blank_a), .busy(busy_a), .frame_done(done_a), .scd_sdclk(sdclk_a),
        .scd_data(data_a), .scd_load_n(load_n_a), .scd_rst_n(rst_n_a)
    );

    scd_frame_serializer #(
        .FRAME_W(25), .NUM_CH(1), .CLK_DIV(1), .LOAD_W(2), .RST_W(4), .MSB_FIRST(0)
    ) u_dut_b (
        .cph1(clk), .pon(pon), .frame_valid(fv_b), .frame_ready(fr_b), .frame_data(fd_b),
        .blank_req(blank_b), .busy(busy_b), .frame_done(done_b), .scd_sdclk(sdclk_b),
        .scd_data(data_b), .scd_load_n(load_n_b), .scd_rst_n(rst_n_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_event(input string name, input longint act);
        tests++;
        fails++;
        $display("FAIL %s: actual %0d required none (cycle %0d)", name, act, cyc);
    endtask

    // Scoreboards
    logic exp_bits_a[$];
    int   exp_done_a[$];
    logic exp_bits_b[$];
    int   exp_done_b[$];

    int   rises_a = 0, done_cnt_a = 0, loads_a = 0, low_w_a = 0;
    logic prev_clk_a = 1'b0, prev_data_a = 1'b0, prev_load_a = 1'b1;
    int   done_cnt_b = 0;
    logic prev_clk_b = 1'b0;

    always @(negedge clk) begin
        if (sdclk_a === 1'b1 && prev_clk_a === 1'b0) begin
            rises_a++;
            if (exp_bits_a.size() == 0) fail_event("a_unexpected_sdclk_rise", rises_a);
            else check("a_bit_on_rise", data_a, exp_bits_a.pop_front());
        end
        if (sdclk_a === 1'b1 && prev_clk_a === 1'b1)
            check("a_data_hold_while_high", data_a, prev_data_a);
        if (load_n_a === 1'b0) begin
            low_w_a++;
        end else if (prev_load_a === 1'b0) begin
            loads_a++;
            check("a_load_width", low_w_a, 2);
            low_w_a = 0;
        end
        if (done_a === 1'b1) begin
            done_cnt_a++;
            if (exp_done_a.size() == 0) fail_event("a_unexpected_frame_done", cyc);
            else check("a_frame_done_cycle", cyc, exp_done_a.pop_front());
            check("a_done_sdclk_low_load_high", {sdclk_a, load_n_a}, 1);
        end
        prev_clk_a  = sdclk_a;
        prev_data_a = data_a;
        prev_load_a = load_n_a;
    end

    always @(negedge clk) begin
        if (sdclk_b === 1'b1 && prev_clk_b === 1'b0) begin
            if (exp_bits_b.size() == 0) fail_event("b_unexpected_sdclk_rise", cyc);
            else check("b_bit_on_rise", data_b, exp_bits_b.pop_front());
        end
        if (done_b === 1'b1) begin
            done_cnt_b++;
            if (exp_done_b.size() == 0) fail_event("b_unexpected_frame_done", cyc);
            else check("b_frame_done_cycle", cyc, exp_done_b.pop_front());
        end
        prev_clk_b = sdclk_b;
    end

    // Offer a frame (called at a negedge); t is the accept edge count.
    task automatic send_a(input logic [49:0] d, output int t);
        int k = 0;
        fv_a = 1'b1;
        fd_a = d;
        while (fr_a !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (fr_a !== 1'b1) begin
            fail_event("a_accept_timeout", k);
            fv_a = 1'b0;
            t = -1;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        t = cyc;
        for (int i = 49; i >= 0; i--) exp_bits_a.push_back(d[i]);
        exp_done_a.push_back(t + 203);
    endtask

    task automatic send_b(input logic [24:0] d, output int t);
        int k = 0;
        fv_b = 1'b1;
        fd_b = d;
        while (fr_b !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (fr_b !== 1'b1) begin
            fail_event("b_accept_timeout", k);
            fv_b = 1'b0;
            t = -1;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        t = cyc;
        for (int i = 0; i < 25; i++) exp_bits_b.push_back(d[i]);
        exp_done_b.push_back(t + 53);
    endtask

    task automatic wait_done_a(input string name);
        int k = 0;
        while (done_a !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (done_a !== 1'b1) fail_event(name, k);
    endtask

    task automatic wait_ready_a(input string name);
        int k = 0;
        while (fr_a !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (fr_a !== 1'b1) fail_event(name, k);
    endtask

    initial begin
        int t1, t2, tb, r0, k;
        pon = 1'b1;
        fv_a = 1'b0; fd_a = '0; blank_a = 1'b0;
        fv_b = 1'b0; fd_b = '0; blank_b = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_sdclk", sdclk_a, 0);
        check("rst_data", data_a, 0);
        check("rst_load_n", load_n_a, 1);
        check("rst_rst_n", rst_n_a, 0);
        check("rst_frame_ready", fr_a, 0);
        check("rst_busy", busy_a, 1);
        check("rst_frame_done", done_a, 0);

        pon = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c <= 3) begin
                check("rst_n_low_after_release", rst_n_a, 0);
            end else if (c == 4) begin
                check("rst_n_rises_after_4", rst_n_a, 1);
                check("ready_low_as_rst_n_rises", fr_a, 0);
            end else begin
                check("ready_after_rst_n", fr_a, 1);
            end
            check("rst_seq_sdclk_low", sdclk_a, 0);
            check("rst_seq_load_n_high", load_n_a, 1);
        end

        // Single-chip LSB-first, CLK_DIV=1
        send_b(25'h1, tb);
        fv_b = 1'b0;
        repeat (60) @(negedge clk);

        // Single default frame
        send_a(50'h2_AAAA_5555_F00F, t1);
        fv_a = 1'b0;
        wait_done_a("a_single_done_timeout");

        // Back-to-back with frame_valid held; data changed mid-shift
        send_a(50'h1_2345_6789_ABCD, t1);
        fd_a = 50'h3_FFFF_0000_1111;
        send_a(50'h3_FFFF_0000_1111, t2);
        fv_a = 1'b0;
        check("b2b_accept_gap", t2 - t1, 204);
        wait_done_a("a_b2b_done_timeout");

        // Blank pulsed mid-shift
        @(negedge clk);
        send_a(50'h0_F0F0_0F0F_3C3C, t1);
        fv_a = 1'b0;
        repeat (60) @(negedge clk);
        blank_a = 1'b1;
        @(negedge clk);
        blank_a = 1'b0;
        wait_done_a("a_blank_done_timeout");
        check("blank_ready_held_in_done", fr_a, 0);
        @(negedge clk);
        check("blank_rst_entered", rst_n_a, 0);
        check("blank_busy", busy_a, 1);
        repeat (3) @(negedge clk);
        check("blank_rst_n_still_low", rst_n_a, 0);
        check("blank_ready_low_in_rst", fr_a, 0);
        @(negedge clk);
        check("blank_rst_n_rises", rst_n_a, 1);
        check("blank_ready_low_at_rise", fr_a, 0);
        @(negedge clk);
        check("blank_ready_after_rst", fr_a, 1);

        // Blank and frame offered together: blank wins
        fd_a = 50'h3_0000_0000_0001;
        fv_a = 1'b1;
        blank_a = 1'b1;
        @(negedge clk);
        fv_a = 1'b0;
        blank_a = 1'b0;
        check("blank_vs_valid_rst_n", rst_n_a, 0);
        check("blank_vs_valid_ready", fr_a, 0);
        wait_ready_a("a_ready_after_blank_timeout");
        repeat (5) @(negedge clk);

        // pon around bit 20 of a shift
        send_a(50'h2_5A5A_A5A5_0FF0, t1);
        fv_a = 1'b0;
        r0 = rises_a;
        k = 0;
        while (rises_a < r0 + 20 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (rises_a < r0 + 20) fail_event("a_bit20_timeout", rises_a - r0);
        pon = 1'b1;
        @(negedge clk);
        check("abort_sdclk", sdclk_a, 0);
        check("abort_data", data_a, 0);
        check("abort_rst_n", rst_n_a, 0);
        check("abort_load_n", load_n_a, 1);
        check("abort_frame_done", done_a, 0);
        exp_bits_a.delete();
        exp_done_a.delete();
        @(negedge clk);
        pon = 1'b0;
        wait_ready_a("a_ready_after_abort_timeout");
        repeat (10) @(negedge clk);

        check("a_frames_done", done_cnt_a, 4);
        check("a_load_pulses", loads_a, 4);
        check("a_bits_left", exp_bits_a.size(), 0);
        check("a_dones_left", exp_done_a.size(), 0);
        check("b_frames_done", done_cnt_b, 1);
        check("b_bits_left", exp_bits_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
